// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one byte-wide SPI master engine among N_REQ requesters.
// Optional transfer watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_bus_arbiter #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned GAP_CYC     = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_byte,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   gnt,
    output logic               ack,
    output logic               err,
    output logic [7:0]         rx_byte,
    output logic [N_REQ-1:0]   ss_n,
    output logic               m_start,
    output logic [7:0]         m_tx,
    input  logic               m_done,
    input  logic [7:0]         m_rx
);

    localparam int unsigned IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned MAX_SG  = (SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC;
    localparam int unsigned CNT_MAX = (MAX_SG > TIMEOUT_CYC) ? MAX_SG : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        START = 3'd2,
        XFER  = 3'd3,
        NEXT  = 3'd4,
        GAP   = 3'd5
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   g, g_d;
    logic               last, last_d;
    logic [N_REQ-1:0]   gnt_d, ss_n_d;
    logic               ack_d, err_d, m_start_d;
    logic [7:0]         m_tx_d, rx_d;
    logic [7:0]         byte_arr [N_REQ];
    logic [IDX_W-1:0]   win;
    logic               found;
    logic               go_gap;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign byte_arr[i] = req_byte[8*i +: 8];
    end

    // First requesting index at or above ptr, wrapping around
    always_comb begin
        int unsigned idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[IDX_W'(idx)]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ptr     <= '0;
            g       <= '0;
            last    <= 1'b0;
            gnt     <= '0;
            ss_n    <= '1;
            ack     <= 1'b0;
            err     <= 1'b0;
            m_start <= 1'b0;
            m_tx    <= 8'h00;
            rx_byte <= 8'h00;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ptr     <= ptr_d;
            g       <= g_d;
            last    <= last_d;
            gnt     <= gnt_d;
            ss_n    <= ss_n_d;
            ack     <= ack_d;
            err     <= err_d;
            m_start <= m_start_d;
            m_tx    <= m_tx_d;
            rx_byte <= rx_d;
        end
    end

    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        ptr_d     = ptr;
        g_d       = g;
        last_d    = last;
        gnt_d     = gnt;
        ss_n_d    = ss_n;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        m_start_d = 1'b0;
        m_tx_d    = m_tx;
        rx_d      = rx_byte;
        go_gap    = 1'b0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    g_d     = win;
                    gnt_d   = N_REQ'(1) << win;
                    ss_n_d  = ~(N_REQ'(1) << win);
                    m_tx_d  = byte_arr[win];
                    last_d  = req_last[win];
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt >= CNT_W'(SETUP_CYC - 1)) begin
                    cnt_d     = '0;
                    m_start_d = 1'b1;
                    state_d   = START;
                end else begin
                    cnt_d = sat_inc(cnt);
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = XFER;
            end
            XFER: begin
                if (m_done) begin
                    rx_d  = m_rx;
                    ack_d = 1'b1;
                    if (last) begin
                        go_gap = 1'b1;
                    end else begin
                        state_d = NEXT;
                    end
                end
`ifdef SPI_ARB_TIMEOUT_EN
                else if (cnt >= CNT_W'(TIMEOUT_CYC - 1)) begin
                    rx_d   = 8'hFF;
                    ack_d  = 1'b1;
                    err_d  = 1'b1;
                    go_gap = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt);
                end
`endif
            end
            NEXT: begin
                // The ack cycle itself is skipped so the requester can update req/req_byte
                if (!ack) begin
                    if (req[g]) begin
                        m_tx_d    = byte_arr[g];
                        last_d    = req_last[g];
                        m_start_d = 1'b1;
                        state_d   = START;
                    end else begin
                        go_gap = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt >= CNT_W'(GAP_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = sat_inc(cnt);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Release the slave and advance the round-robin pointer past the winner
        if (go_gap) begin
            state_d = GAP;
            cnt_d   = '0;
            gnt_d   = '0;
            ss_n_d  = '1;
            ptr_d   = (g == IDX_W'(N_REQ - 1)) ? '0 : g + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter with a simple hand-driven SPI engine.
module tb_spi_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] req_byte;
    logic [3:0]  req_last;
    logic [3:0]  gnt;
    logic        ack;
    logic        err;
    logic [7:0]  rx_byte;
    logic [3:0]  ss_n;
    logic        m_start;
    logic [7:0]  m_tx;
    logic        m_done;
    logic [7:0]  m_rx;

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_ack = 0;
    int n_fall = 0;
    logic [3:0] ss_prev = 4'hF;

    spi_bus_arbiter #(
        .N_REQ(4), .SETUP_CYC(2), .GAP_CYC(2), .TIMEOUT_CYC(64)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_byte(req_byte), .req_last(req_last),
        .gnt(gnt), .ack(ack), .err(err), .rx_byte(rx_byte), .ss_n(ss_n),
        .m_start(m_start), .m_tx(m_tx), .m_done(m_done), .m_rx(m_rx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event counters sampled mid-cycle
    always @(negedge clk) begin
        if (m_start) n_start <= n_start + 1;
        if (ack) n_ack <= n_ack + 1;
        if (ss_prev == 4'hF && ss_n != 4'hF) n_fall <= n_fall + 1;
        ss_prev <= ss_n;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for m_start, answers one cycle later, returns at the ack cycle
    task automatic engine(input logic [7:0] rx, output logic [3:0] g, output logic [7:0] tx,
                          output int nwait);
        nwait = 0;
        while (!m_start && nwait < 40) begin
            tick();
            nwait++;
        end
        if (!m_start) begin
            check("m_start_wait", 32'd0, 32'd1);
            g  = '0;
            tx = '0;
            return;
        end
        g  = gnt;
        tx = m_tx;
        tick();
        m_done = 1'b1;
        m_rx   = rx;
        tick();
        m_done = 1'b0;
        check("ack", 32'(ack), 32'd1);
        check("rx_byte", 32'(rx_byte), 32'(rx));
    endtask

    initial begin
        logic [3:0] g;
        logic [7:0] tx;
        int nw;
        int s0, a0, f0;

        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] g;
        logic [7:0] tx;
        int nw;
        int s0, a0, f0;

        reset = 1'b0; req = '0; req_byte = '0; req_last = '0; m_done = 1'b0; m_rx = '0;
        tick(); tick();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_ss_n", 32'(ss_n), 32'hF);
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_rx", 32'(rx_byte), 32'h00);
        check("rst_m_start", 32'(m_start), 32'h0);
        check("rst_m_tx", 32'(m_tx), 32'h00);
        reset = 1'b1;
        tick();

        // Stray m_done while idle
        m_done = 1'b1; m_rx = 8'h77;
        tick();
        m_done = 1'b0;
        tick();
        check("idle_done_ack", 32'(ack), 32'h0);
        check("idle_done_rx", 32'(rx_byte), 32'h00);
        check("idle_ss_n", 32'(ss_n), 32'hF);

        // Single byte on requester 1, then immediate re-request
        req = 4'b0010; req_byte[15:8] = 8'hA5; req_last = 4'b0010;
        tick();
        check("single_gnt", 32'(gnt), 32'b0010);
        check("single_ss_n", 32'(ss_n), 32'b1101);
        check("single_setup_m_start", 32'(m_start), 32'h0);
        engine(8'h3C, g, tx, nw);
        check("single_setup_lat", 32'(nw), 32'd2);
        check("single_m_tx", 32'(tx), 32'hA5);
        check("single_rel_ss_n", 32'(ss_n), 32'hF);
        check("single_rel_gnt", 32'(gnt), 32'h0);
        req_byte[15:8] = 8'h5C;
        tick();
        check("gap1_ss_n", 32'(ss_n), 32'hF);
        check("gap1_ack", 32'(ack), 32'h0);
        tick();
        check("gap2_ss_n", 32'(ss_n), 32'hF);
        tick();
        check("regrant_ss_n", 32'(ss_n), 32'b1101);
        engine(8'hC3, g, tx, nw);
        check("regrant_m_tx", 32'(tx), 32'h5C);
        req = '0;

        // Reset asserted while m_start is high
        req = 4'b1000; req_byte[31:24] = 8'h99; req_last = 4'b1000;
        nw = 0;
        while (!m_start && nw < 40) begin
            tick();
            nw++;
        end
        check("pre_reset_m_start", 32'(m_start), 32'h1);
        reset = 1'b0;
        #1;
        check("midrst_ss_n", 32'(ss_n), 32'hF);
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_m_start", 32'(m_start), 32'h0);
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_rx", 32'(rx_byte), 32'h00);
        req = '0;
        tick();
        reset = 1'b1;
        tick();

        // Round robin with all four requesting single bytes
        req = 4'b1111; req_last = 4'b1111; req_byte = 32'h43322110;
        for (int k = 0; k < 5; k++) begin
            engine(8'(k), g, tx, nw);
            check($sformatf("rr_gnt%0d", k), 32'(g), 32'(4'b0001 << (k % 4)));
            check($sformatf("rr_tx%0d", k), 32'(tx), 32'h10 + 32'h11 * 32'(k % 4));
        end
        req = '0;
        repeat (4) tick();

        // Three-byte burst on requester 2, with requester 0 requesting meanwhile
        s0 = n_start; a0 = n_ack; f0 = n_fall;
        req = 4'b0100; req_last = 4'b0000; req_byte = 32'h00110000;
        engine(8'hB1, g, tx, nw);
        check("burst_gnt0", 32'(g), 32'b0100);
        check("burst_tx0", 32'(tx), 32'h11);
        req = 4'b0101; req_byte = 32'h002200EE; req_last = 4'b0001;
        engine(8'hB2, g, tx, nw);
        check("burst_gnt1", 32'(g), 32'b0100);
        check("burst_tx1", 32'(tx), 32'h22);
        check("burst_ss_n1", 32'(ss_n), 32'b1011);
        req_byte[23:16] = 8'h33; req_last = 4'b0101;
        engine(8'hB3, g, tx, nw);
        check("burst_gnt2", 32'(g), 32'b0100);
        check("burst_tx2", 32'(tx), 32'h33);
        req = '0;
        repeat (4) tick();
        check("burst_starts", 32'(n_start - s0), 32'd3);
        check("burst_acks", 32'(n_ack - a0), 32'd3);
        check("burst_setups", 32'(n_fall - f0), 32'd1);

        // Early burst termination on requester 0
        s0 = n_start;
        req = 4'b0001; req_last = 4'b0000; req_byte = 32'h0000005A;
        engine(8'h4D, g, tx, nw);
        check("early_gnt", 32'(g), 32'b0001);
        check("early_tx", 32'(tx), 32'h5A);
        req = '0;
        repeat (6) tick();
        check("early_starts", 32'(n_start - s0), 32'd1);
        check("early_ss_n", 32'(ss_n), 32'hF);
        check("early_gnt_off", 32'(gnt), 32'h0);

`ifdef SPI_ARB_TIMEOUT_EN
        // No m_done: watchdog aborts after 64 cycles in XFER
        req = 4'b0010; req_last = 4'b0000; req_byte = 32'h00006600;
        nw = 0;
        while (!m_start && nw < 40) begin
            tick();
            nw++;
        end
        check("to_m_start", 32'(m_start), 32'h1);
        nw = 0;
        while (!ack && nw < 100) begin
            tick();
            nw++;
        end
        check("to_latency", 32'(nw), 32'd65);
        check("to_err", 32'(err), 32'h1);
        check("to_rx", 32'(rx_byte), 32'hFF);
        check("to_ss_n", 32'(ss_n), 32'hF);
        req = '0;
        m_done = 1'b1; m_rx = 8'h12;
        tick();
        m_done = 1'b0;
        tick();
        check("to_late_err", 32'(err), 32'h0);
        check("to_late_rx", 32'(rx_byte), 32'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
